// File: rtl/regfile_dump_reader.sv
// Walks the register file read port and streams each word on valid/ready.
// REGDUMP_CHECKSUM_EN appends a modular-sum word after the last register.
module regfile_dump_reader #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_idx,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_SEND,
`ifdef REGDUMP_CHECKSUM_EN
    S_CSUM,
`endif
    S_FINISH
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_REGS - 1);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] idx, idx_n;
  logic [DATA_WIDTH-1:0] cap, cap_n;

`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] acc, acc_n;
`endif

  assign rf_raddr = idx;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      idx   <= '0;
      cap   <= '0;
`ifdef REGDUMP_CHECKSUM_EN
      acc   <= '0;
`endif
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cap   <= cap_n;
`ifdef REGDUMP_CHECKSUM_EN
      acc   <= acc_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cap_n     = cap;
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    done      = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
    acc_n     = acc;
`endif
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_READ;
          idx_n   = '0;
`ifdef REGDUMP_CHECKSUM_EN
          acc_n   = '0;
`endif
        end
      end
      S_READ: begin
        cap_n   = rf_rdata;
        state_n = S_SEND;
      end
      S_SEND: begin
        out_valid = 1'b1;
        out_data  = cap;
        out_idx   = idx;
`ifndef REGDUMP_CHECKSUM_EN
        out_last  = (idx == LAST);
`endif
        if (out_ready) begin
`ifdef REGDUMP_CHECKSUM_EN
          acc_n = acc + cap;
`endif
          if (idx == LAST) begin
`ifdef REGDUMP_CHECKSUM_EN
            state_n = S_CSUM;
`else
            state_n = S_FINISH;
`endif
          end else begin
            idx_n   = idx + 1'b1;
            state_n = S_READ;
          end
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      // Trailing word carries the sum of every register accepted.
      S_CSUM: begin
        out_valid = 1'b1;
        out_data  = acc;
        out_idx   = '0;
        out_last  = 1'b1;
        if (out_ready) state_n = S_FINISH;
      end
`endif
      S_FINISH: begin
        done    = 1'b1;
        idx_n   = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader.
// Build with REGDUMP_CHECKSUM_EN to cover the checksum word.
module tb_regfile_dump_reader;

`ifdef REGDUMP_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam int NW = CSUM ? 33 : 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;

  logic        ovr;
  logic [31:0] mul;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb rf_rdata = ovr ? 32'hDEADBEEF : ({27'd0, rf_raddr} * mul);

  regfile_dump_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idx(input int target, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (out_valid && out_idx == 5'(target)) begin
        out_ready = 1'b0;
        ok = 1'b1;
        break;
      end
      out_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic drain(output int dones, output bit ok);
    dones = 0;
    ok = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (done) dones++;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    ovr = 1'b0;
    mul = 32'h11;
    #3;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL reset_ctrl: valid=%b busy=%b done=%b expected 0 0 0", out_valid, busy, done); end
    checks++;
    if (rf_raddr !== 5'd0 || out_idx !== 5'd0 || out_last !== 1'b0)
      begin errors++; $display("FAIL reset_idx: raddr=%0d idx=%0d last=%b expected 0 0 0", rf_raddr, out_idx, out_last); end
    checks++;
    if (out_data !== 32'd0)
      begin errors++; $display("FAIL reset_data: got %h expected 0", out_data); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL idle_after_reset: busy=%b valid=%b expected 0 0", busy, out_valid); end
  endtask

  task automatic test_full_dump();
    int n;
    int dones;
    int c;
    logic [31:0] ed;
    logic [4:0]  ei;
    logic        el;
    mul = 32'h11;
    out_ready = 1'b1;
    do_start();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1)
      begin errors++; $display("FAIL latency_read: valid=%b busy=%b expected 0 1", out_valid, busy); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 5'd0)
      begin errors++; $display("FAIL first_valid: valid=%b idx=%0d expected 1 0", out_valid, out_idx); end
    n = 0;
    dones = 0;
    for (c = 0; c < 400; c++) begin
      if (done) dones++;
      if (!busy) break;
      if (out_valid) begin
        if (n < 32) begin
          ei = 5'(n);
          ed = 32'(n) * 32'h11;
          el = !CSUM && (n == 31);
        end else begin
          ei = 5'd0;
          ed = 32'h20F0;
          el = 1'b1;
        end
        checks++;
        if (out_idx !== ei)
          begin errors++; $display("FAIL word_idx[%0d]: got %0d expected %0d", n, out_idx, ei); end
        checks++;
        if (out_data !== ed)
          begin errors++; $display("FAIL word_data[%0d]: got %h expected %h", n, out_data, ed); end
        checks++;
        if (out_last !== el)
          begin errors++; $display("FAIL word_last[%0d]: got %b expected %b", n, out_last, el); end
        n++;
      end else begin
        checks++;
        if (out_last !== 1'b0)
          begin errors++; $display("FAIL last_without_valid: got %b expected 0", out_last); end
      end
      @(negedge clk);
    end
    checks++;
    if (n != NW)
      begin errors++; $display("FAIL word_count: got %0d expected %0d", n, NW); end
    checks++;
    if (dones != 1)
      begin errors++; $display("FAIL done_pulses: got %0d expected 1", dones); end
    checks++;
    if (busy !== 1'b0)
      begin errors++; $display("FAIL busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int dones;
    mul = 32'h11;
    do_start();
    wait_idx(3, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_reach: got timeout expected idx 3"); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h33 || out_idx !== 5'd3)
        begin errors++; $display("FAIL bp_hold[%0d]: valid=%b data=%h idx=%0d expected 1 33 3", i, out_valid, out_data, out_idx); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || rf_raddr !== 5'd4)
      begin errors++; $display("FAIL bp_advance: valid=%b raddr=%0d expected 0 4", out_valid, rf_raddr); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h44 || out_idx !== 5'd4)
      begin errors++; $display("FAIL bp_resume: valid=%b data=%h idx=%0d expected 1 44 4", out_valid, out_data, out_idx); end
    drain(dones, ok);
    checks++;
    if (!ok || dones != 1)
      begin errors++; $display("FAIL bp_drain: ok=%b dones=%0d expected 1 1", ok, dones); end
  endtask

  task automatic test_rdata_hold();
    bit ok;
    int dones;
    mul = 32'h11;
    do_start();
    wait_idx(7, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL hold_reach: got timeout expected idx 7"); end
    ovr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_data !== 32'h77 || out_idx !== 5'd7)
        begin errors++; $display("FAIL rdata_hold[%0d]: data=%h idx=%0d expected 77 7", i, out_data, out_idx); end
    end
    ovr = 1'b0;
    drain(dones, ok);
    checks++;
    if (!ok || dones != 1)
      begin errors++; $display("FAIL hold_drain: ok=%b dones=%0d expected 1 1", ok, dones); end
  endtask

  task automatic test_start_ignored();
    bit ok;
    int dones;
    mul = 32'h11;
    do_start();
    wait_idx(12, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ign_reach: got timeout expected idx 12"); end
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 5'd13 || out_data !== 32'hDD)
      begin errors++; $display("FAIL ign_next: valid=%b idx=%0d data=%h expected 1 13 dd", out_valid, out_idx, out_data); end
    drain(dones, ok);
    checks++;
    if (!ok || dones != 1)
      begin errors++; $display("FAIL ign_done: ok=%b dones=%0d expected 1 1", ok, dones); end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0)
      begin errors++; $display("FAIL ign_not_queued: busy=%b expected 0", busy); end
  endtask

  task automatic test_async_reset();
    bit ok;
    int dones;
    mul = 32'h11;
    do_start();
    wait_idx(10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_reach: got timeout expected idx 10"); end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rf_raddr !== 5'd0)
      begin errors++; $display("FAIL async_reset: valid=%b busy=%b done=%b raddr=%0d expected 0 0 0 0", out_valid, busy, done, rf_raddr); end
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    do_start();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 5'd0 || out_data !== 32'd0)
      begin errors++; $display("FAIL restart: valid=%b idx=%0d data=%h expected 1 0 0", out_valid, out_idx, out_data); end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 5'd1 || out_data !== 32'h11)
      begin errors++; $display("FAIL restart_next: valid=%b idx=%0d data=%h expected 1 1 11", out_valid, out_idx, out_data); end
    drain(dones, ok);
    checks++;
    if (!ok || dones != 1)
      begin errors++; $display("FAIL rst_drain: ok=%b dones=%0d expected 1 1", ok, dones); end
  endtask

`ifdef REGDUMP_CHECKSUM_EN
  task automatic test_checksum();
    bit ok;
    int dones;
    mul = 32'd1;
    do_start();
    wait_idx(31, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL cs_reach: got timeout expected idx 31"); end
    checks++;
    if (out_last !== 1'b0 || out_data !== 32'd31)
      begin errors++; $display("FAIL cs_reg31: last=%b data=%h expected 0 1f", out_last, out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h000001F0 || out_idx !== 5'd0 || out_last !== 1'b1)
      begin errors++; $display("FAIL cs_word: valid=%b data=%h idx=%0d last=%b expected 1 1f0 0 1", out_valid, out_data, out_idx, out_last); end
    drain(dones, ok);
    checks++;
    if (!ok || dones != 1)
      begin errors++; $display("FAIL cs_drain: ok=%b dones=%0d expected 1 1", ok, dones); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_rdata_hold();
    test_start_ignored();
    test_async_reset();
`ifdef REGDUMP_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
